// File: rtl/pc_seq.sv
// pc_seq: five-phase instruction sequencer for the 16-bit core.
// Owns the program counter and instruction register, steps P1..P5,
// applies the branch decision at commit and parks in HALT on HLT.
module pc_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] imem_data,
  input  logic        jflag,
  input  logic        stall,
  input  logic        resume,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [4:0]  phase,
  output logic        commit,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_P1   = 3'd0,
    S_P2   = 3'd1,
    S_P3   = 3'd2,
    S_P4   = 3'd3,
    S_P5   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  logic        is_hlt;
  logic        step_ok;
  logic [15:0] branch_off;
  logic [15:0] pc_inc;
  logic [15:0] pc_target;

  // HLT is recognised from the class bits and the sub-op nibble only.
  assign is_hlt     = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'hF);
  // A stall freezes every phase except HALT, which ignores it.
  assign step_ok    = !stall;
  assign branch_off = {{8{ir_q[7]}}, ir_q[7:0]};
  assign pc_inc     = pc_q + 16'd1;
  assign pc_target  = pc_inc + branch_off;

  // State, PC and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_P1;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state: advance one phase per unstalled cycle, HALT after an HLT commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P1:    if (step_ok) state_d = S_P2;
      S_P2:    if (step_ok) state_d = S_P3;
      S_P3:    if (step_ok) state_d = S_P4;
      S_P4:    if (step_ok) state_d = S_P5;
      S_P5:    if (step_ok) state_d = is_hlt ? S_HALT : S_P1;
      S_HALT:  if (resume)  state_d = S_P1;
      default: state_d = S_P1;
    endcase
  end

  // Datapath next values: fetch in P1, PC update at the P5 commit.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (state_q == S_P1 && step_ok) begin
      ir_d = imem_data;
    end
    if (state_q == S_P5 && step_ok) begin
      // HLT always falls through; the branch decision is ignored for it.
      pc_d = (jflag && !is_hlt) ? pc_target : pc_inc;
    end
  end

  // Outputs decoded from the registered state (commit also needs stall).
  always_comb begin
    phase  = 5'b00000;
    commit = 1'b0;
    halted = 1'b0;
    case (state_q)
      S_P1:    phase = 5'b00001;
      S_P2:    phase = 5'b00010;
      S_P3:    phase = 5'b00100;
      S_P4:    phase = 5'b01000;
      S_P5: begin
        phase  = 5'b10000;
        commit = step_ok;
      end
      S_HALT:  halted = 1'b1;
      default: phase = 5'b00000;
    endcase
  end

  assign pc = pc_q;
  assign ir = ir_q;

endmodule

// File: doc/pc_seq.md
# pc_seq

Multi-cycle instruction sequencer for the 16-bit core. It owns the program counter, fetches each instruction into the instruction register, and steps the five-phase execution cycle (P1–P5). It consumes the branch decision (`jflag`) produced by the branch/destination decoder and uses it to choose the next PC at commit. It also handles the HLT instruction and pipeline stall.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_data`  in  16  instruction memory read data; combinational read at address `pc`.
- `jflag`  in  1  branch-taken decision for the instruction in `ir`; sampled in P5 only.
- `stall`  in  1  freezes phase, `pc` and `ir` while high (except in HALT).
- `resume`  in  1  leaves HALT.
- `pc`  out  16  program counter; also the instruction memory address.
- `ir`  out  16  instruction register.
- `phase`  out  5  one-hot phase: bit0=P1 … bit4=P5; 5'b00000 in HALT.
- `commit`  out  1  high during any P5 cycle with `stall`=0.
- `halted`  out  1  high in HALT.

## Operation
- States: P1, P2, P3, P4, P5, HALT. Registered state; `phase`, `commit` and `halted` decode from it.
- Normal sequence is P1→P2→P3→P4→P5→P1. The sequence advances one step per cycle when `stall`=0 and holds otherwise.
- P1 with `stall`=0: `ir` <= `imem_data`. `ir` is unchanged in every other phase.
- P5 with `stall`=0 is the commit step:
  - If `jflag`=1: `pc` <= `pc` + 1 + sext(`ir[7:0]`).
  - Otherwise: `pc` <= `pc` + 1.
  - All arithmetic is 16-bit modulo 2^16. 16'hFFFF+1 wraps to 16'h0000, and negative offsets wrap below 0.
- HLT decode is `ir[15:14]`=2'b11 and `ir[7:4]`=4'b1111. In P5 with an HLT instruction:
  - `pc` <= `pc` + 1. `jflag` is ignored.
  - The next state is HALT, not P1.
- HALT:
  - `pc` and `ir` hold; `stall` is ignored.
  - `resume`=1 moves the state to P1 on the next edge.
- `jflag` outside P5 has no effect, and neither does `resume` outside HALT.
- The sequencer does not decode any other instruction fields.
- `rst`=1 at any edge, in any state including mid-cycle, forces:
  - state P1, `pc`=`RESET_PC`, `ir`=16'h0000;
  - `phase`=5'b00001, `commit`=0, `halted`=0.
  
  `rst` overrides `stall` and `resume`.

## Timing
- Every instruction takes exactly 5 unstalled cycles. Each stalled cycle adds exactly one cycle.
- `ir` holds the fetched word from the cycle after P1 (i.e. in P2) until the next P1 capture.
- The new `pc` is visible in the P1 cycle that follows commit. Fetch in that P1 uses the new `pc`.
- `commit` is combinational from state and `stall`: it is high in the same cycle as the P5 edge that updates `pc`.
- `stall`=1 in P5 delays commit. `jflag` is re-sampled in the P5 cycle where `stall` finally drops.
- From HLT commit: HALT is reached one cycle after P5. Leaving HALT takes one cycle after `resume` is sampled high.
- First fetch after reset release: P1 in the first cycle with `rst`=0, `pc`=`RESET_PC`.

## Test plan
- Reset: hold `rst` 2 cycles mid-P3 with `pc`=16'h0042 -> `pc`=16'h0000, `ir`=0, `phase`=5'b00001, `halted`=0, `commit`=0.
- Sequential fetch: memory holds three non-branch words at 0,1,2, `jflag`=0 -> `ir` loads each in turn, `pc` goes 0→1→2→3 at 5-cycle intervals, `commit` pulses once per instruction.
- Branch:
  - Taken: `pc`=16'h0010, `ir[7:0]`=8'hFE, `jflag`=1 in P5 -> `pc`=16'h000F.
  - Offset 8'h05 with `jflag` pulsed only in P3 -> `pc`=16'h0011 (not taken).
- Stall: `stall`=1 for 3 cycles in P2, then for 2 cycles in P5 with `jflag` low then high at release -> instruction takes 10 cycles; `pc` uses the `jflag` value at the release cycle.
- Halt:
  - HLT word 16'hC0F0 at `pc`=16'h0005 -> `pc`=16'h0006, `halted`=1, `phase`=0.
  - `stall` toggling while halted changes nothing.
  - `resume`=1 -> P1 next cycle, fetch from 16'h0006.
- Wrap:
  - `pc`=16'hFFFF, `jflag`=0 -> `pc`=16'h0000.
  - `pc`=16'h0000, offset 8'h80, `jflag`=1 -> `pc`=16'hFF81.
